axim_wr_ctrl: RTL and testbench
===============================

// Module: axim_wr_ctrl
// PURPOSE
//  AXI4 master write-channel controller on the far side of mem_subsys's ctrl_w*/wr_t* interface.
//  Takes one transfer command (start, byte address, byte size) and consumes the wr_tdata stream.
//  Splits the transfer into INCR bursts that respect MAX_BURST_LEN and 4KB boundaries.
//  Drives AW/W/B and pulses ctrl_wdone once every burst response has been received.
// PARAMETERS
//  C_M_AXI_ADDR_WIDTH  32  AXI address width, also ctrl_waddr_offset width
//  C_M_AXI_DATA_WIDTH  32  AXI and stream data width; BYTES = C_M_AXI_DATA_WIDTH/8
//  C_XFER_SIZE_WIDTH   32  width of the byte-count command
//  MAX_BURST_LEN       16  maximum beats per burst (1..256, power of 2)
// PORTS
//  clk                  in   1    clock; all logic on rising edge
//  rstn                 in   1    synchronous active-low reset
//  ctrl_waddr_offset_i  in   AW   start byte address; low log2(BYTES) bits ignored (treated 0)
//  ctrl_wxfer_size_i    in   XS   transfer length in bytes
//  ctrl_wstart_i        in   1    1-cycle command strobe; sampled only in IDLE
//  ctrl_wdone_o         out  1    1-cycle pulse: transfer complete
//  ctrl_werr_o          out  1    sticky: a burst returned BRESP!=OKAY; cleared on next accepted start
//  wr_tdata_i           in   DW   write data stream from mem_subsys
//  wr_tvalid_i          in   1    stream valid
//  wr_tready_o          out  1    stream ready (= m_axi_wready while in W_DATA)
//  m_axi_awvalid_o/awready_i, awaddr_o[AW], awlen_o[8], awsize_o[3], awburst_o[2]
//  m_axi_wvalid_o/wready_i, wdata_o[DW], wstrb_o[BYTES], wlast_o
//  m_axi_bvalid_i/bready_o, bresp_i[2]
// BEHAVIOUR
//  Reset: FSM->IDLE; awvalid, wvalid, wlast, bready, wr_tready, ctrl_wdone, ctrl_werr = 0; counters 0.
//  Reset mid-transfer abandons it without a done pulse; AXI valids drop on the next edge.
//  Command latch, IDLE & ctrl_wstart: addr <= offset aligned to BYTES; beats_rem <= ceil(size/BYTES);
//    tail_bytes <= size mod BYTES (0 = full word); ctrl_werr <= 0.
//    size==0: go to DONE directly, with no AXI traffic. ctrl_wstart outside IDLE is ignored.
//  States: IDLE -> AW -> W_DATA -> B_RESP -> (AW if beats_rem>0 else DONE) -> IDLE.
//  AW: burst_len = min(beats_rem, MAX_BURST_LEN, (4096-addr[11:0])/BYTES), computed in the
//    cycle AW is entered. awvalid=1 and awaddr/awlen(=burst_len-1)/awsize(=log2 BYTES)/awburst(=01) stay stable
//    until awready. On handshake go to W_DATA and drop awvalid.
//  W_DATA: combinational pass-through. m_axi_wvalid = wr_tvalid, wdata = wr_tdata, wr_tready = m_axi_wready.
//    Beat counts on wvalid&wready. wlast=1 on the beat with count==burst_len-1.
//    wstrb all ones, except the final beat of the whole transfer when tail_bytes!=0:
//    wstrb = (1<<tail_bytes)-1. After the last beat: addr += burst_len*BYTES,
//    beats_rem -= burst_len; go to B_RESP.
//  B_RESP: bready=1; on bvalid, OR (bresp!=2'b00) into ctrl_werr. Only one burst is outstanding at a time.
//  DONE: ctrl_wdone=1 for exactly one cycle; return to IDLE, where a new start is accepted next cycle.
//  Address arithmetic wraps modulo 2^AW. Bursts never cross a 4KB boundary.
//  Data must not appear on W before its AW handshake; this is guaranteed by the state ordering.
//  Backpressure: either side may stall any number of cycles; no data is lost or duplicated.
// TESTING
//  1 start addr=0x4000_0000 size=4096, always ready -> 64 bursts awlen=15, addr step 0x40,
//    1024 beats, one done pulse.
//  2 addr=0x0000_0FF0 size=64 -> burst1 addr 0xFF0 awlen=3, burst2 addr 0x1000 awlen=11;
//    no 4KB crossing.
//  3 size=10 addr=0x100 -> awlen=2, beat3 wstrb=4'b0011 wlast=1, done; size=0 -> done next cycles,
//    no awvalid.
//  4 random wready/wr_tvalid/awready/bvalid stalls, size=4096 -> stream word sequence equals wdata
//    sequence, done once.
//  5 bresp=2'b10 on burst 2 of 4 -> transfer completes, werr=1 with done; next start clears werr.
//  6 rstn low in W_DATA mid-burst, then new start -> all outputs at reset values, clean new
//    transfer; start pulse while busy ignored.

Source files
------------

// File: rtl/axim_wr_ctrl_if.sv
//------------------------------------------------------------------------------
// axim_wr_ctrl_if
// AXI4 write-channel bundle (AW/W/B) between a write master and a slave.
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

interface axim_wr_ctrl_if #(
   parameter int ADDR_WIDTH = 32,
   parameter int DATA_WIDTH = 32
);
   localparam int STRB_WIDTH = DATA_WIDTH / 8;

   logic                  awvalid;
   logic                  awready;
   logic [ADDR_WIDTH-1:0] awaddr;
   logic [7:0]            awlen;
   logic [2:0]            awsize;
   logic [1:0]            awburst;

   logic                  wvalid;
   logic                  wready;
   logic [DATA_WIDTH-1:0] wdata;
   logic [STRB_WIDTH-1:0] wstrb;
   logic                  wlast;

   logic                  bvalid;
   logic                  bready;
   logic [1:0]            bresp;

   modport master (
      output awvalid, awaddr, awlen, awsize, awburst,
      input  awready,
      output wvalid, wdata, wstrb, wlast,
      input  wready,
      input  bvalid, bresp,
      output bready
   );

   modport slave (
      input  awvalid, awaddr, awlen, awsize, awburst,
      output awready,
      input  wvalid, wdata, wstrb, wlast,
      output wready,
      output bvalid, bresp,
      input  bready
   );
endinterface

`default_nettype wire

// File: rtl/axim_wr_ctrl.sv
//------------------------------------------------------------------------------
// axim_wr_ctrl
// AXI4 write master: splits one byte-sized transfer command into INCR bursts
// (bounded by MAX_BURST_LEN and 4KB pages) and streams wr_tdata onto W.
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module axim_wr_ctrl #(
   parameter int C_M_AXI_ADDR_WIDTH = 32,
   parameter int C_M_AXI_DATA_WIDTH = 32,
   parameter int C_XFER_SIZE_WIDTH  = 32,
   parameter int MAX_BURST_LEN      = 16
) (
   input  wire logic                          clk,
   input  wire logic                          rstn,
   input  wire logic [C_M_AXI_ADDR_WIDTH-1:0] ctrl_waddr_offset_i,
   input  wire logic [C_XFER_SIZE_WIDTH-1:0]  ctrl_wxfer_size_i,
   input  wire logic                          ctrl_wstart_i,
   output logic                               ctrl_wdone_o,
   output logic                               ctrl_werr_o,
   input  wire logic [C_M_AXI_DATA_WIDTH-1:0] wr_tdata_i,
   input  wire logic                          wr_tvalid_i,
   output logic                               wr_tready_o,
   axim_wr_ctrl_if.master                     m_axi
);

   localparam int ADDR_W = C_M_AXI_ADDR_WIDTH;
   localparam int XS_W   = C_XFER_SIZE_WIDTH;
   localparam int BYTES  = C_M_AXI_DATA_WIDTH / 8;
   localparam int LOG2B  = $clog2(BYTES);
   localparam int TW     = LOG2B + 1;
   localparam int CW     = (XS_W > 13) ? XS_W : 13;

   localparam logic [2:0] S_IDLE   = 3'd0;
   localparam logic [2:0] S_AW     = 3'd1;
   localparam logic [2:0] S_W_DATA = 3'd2;
   localparam logic [2:0] S_B_RESP = 3'd3;
   localparam logic [2:0] S_DONE   = 3'd4;

   logic [2:0]        state;
   logic [2:0]        next_state;
   logic [ADDR_W-1:0] addr;
   logic [XS_W-1:0]   beats_rem;
   logic [TW-1:0]     tail_bytes;
   logic [8:0]        burst_len;
   logic [8:0]        beat_cnt;
   logic              werr;

   logic [XS_W-1:0]   start_tail;
   logic [XS_W-1:0]   start_beats;
   logic [CW-1:0]     page_beats;
   logic [CW-1:0]     rem_ext;
   logic [CW-1:0]     len_cap;
   logic [8:0]        calc_len;
   logic [8:0]        awlen_full;
   logic              w_fire;
   logic              last_beat;
   logic              final_burst;

   // Command decode and burst sizing; addr/beats_rem are stable throughout AW,
   // so awlen derived here holds steady until the handshake.
   always_comb begin
      start_tail  = ctrl_wxfer_size_i & XS_W'(BYTES - 1);
      start_beats = (ctrl_wxfer_size_i >> LOG2B) + XS_W'(start_tail != '0);
      page_beats  = CW'((13'd4096 - {1'b0, addr[11:0]}) >> LOG2B);
      rem_ext     = CW'(beats_rem);
      len_cap     = CW'(MAX_BURST_LEN);
      if (page_beats < len_cap) len_cap = page_beats;
      if (rem_ext < len_cap)    len_cap = rem_ext;
      calc_len    = len_cap[8:0];
      awlen_full  = calc_len - 9'd1;
      w_fire      = (state == S_W_DATA) && wr_tvalid_i && m_axi.wready;
      last_beat   = (beat_cnt == burst_len - 9'd1);
      final_burst = (beats_rem == XS_W'(burst_len));
   end

   // State register
   always_ff @(posedge clk) begin
      if (!rstn) state <= S_IDLE;
      else       state <= next_state;
   end

   // Transfer bookkeeping: address, remaining beats, per-burst beat count, error flag
   always_ff @(posedge clk) begin
      if (!rstn) begin
         addr       <= '0;
         beats_rem  <= '0;
         tail_bytes <= '0;
         burst_len  <= '0;
         beat_cnt   <= '0;
         werr       <= 1'b0;
      end else begin
         case (state)
            S_IDLE: begin
               if (ctrl_wstart_i) begin
                  addr       <= ctrl_waddr_offset_i & ~ADDR_W'(BYTES - 1);
                  beats_rem  <= start_beats;
                  tail_bytes <= start_tail[TW-1:0];
                  werr       <= 1'b0;
               end
            end
            S_AW: begin
               if (m_axi.awready) begin
                  burst_len <= calc_len;
                  beat_cnt  <= '0;
               end
            end
            S_W_DATA: begin
               if (w_fire) begin
                  if (last_beat) begin
                     addr      <= addr + (ADDR_W'(burst_len) << LOG2B);
                     beats_rem <= beats_rem - XS_W'(burst_len);
                     beat_cnt  <= '0;
                  end else begin
                     beat_cnt  <= beat_cnt + 9'd1;
                  end
               end
            end
            S_B_RESP: begin
               if (m_axi.bvalid && (m_axi.bresp != 2'b00)) werr <= 1'b1;
            end
            default: ;
         endcase
      end
   end

   // Next-state: one burst outstanding at a time, AW always precedes its data
   always_comb begin
      next_state = state;
      case (state)
         S_IDLE:   if (ctrl_wstart_i)
                      next_state = (ctrl_wxfer_size_i == '0) ? S_DONE : S_AW;
         S_AW:     if (m_axi.awready) next_state = S_W_DATA;
         S_W_DATA: if (w_fire && last_beat) next_state = S_B_RESP;
         S_B_RESP: if (m_axi.bvalid)
                      next_state = (beats_rem != '0) ? S_AW : S_DONE;
         S_DONE:   next_state = S_IDLE;
         default:  next_state = S_IDLE;
      endcase
   end

   // Outputs: W is a combinational pass-through of the stream while in W_DATA
   always_comb begin
      m_axi.awvalid = 1'b0;
      m_axi.awaddr  = addr;
      m_axi.awlen   = awlen_full[7:0];
      m_axi.awsize  = 3'(LOG2B);
      m_axi.awburst = 2'b01;
      m_axi.wvalid  = 1'b0;
      m_axi.wdata   = wr_tdata_i;
      m_axi.wstrb   = '1;
      m_axi.wlast   = 1'b0;
      m_axi.bready  = 1'b0;
      wr_tready_o   = 1'b0;
      ctrl_wdone_o  = 1'b0;
      ctrl_werr_o   = werr;
      case (state)
         S_AW: m_axi.awvalid = 1'b1;
         S_W_DATA: begin
            m_axi.wvalid = wr_tvalid_i;
            wr_tready_o  = m_axi.wready;
            m_axi.wlast  = last_beat;
            if (final_burst && last_beat && (tail_bytes != '0)) begin
               for (int i = 0; i < BYTES; i++)
                  m_axi.wstrb[i] = (TW'(i) < tail_bytes);
            end
         end
         S_B_RESP: m_axi.bready = 1'b1;
         S_DONE:   ctrl_wdone_o = 1'b1;
         default: ;
      endcase
   end

endmodule

`default_nettype wire

// File: tb/tb_axim_wr_ctrl.sv
//------------------------------------------------------------------------------
// tb_axim_wr_ctrl
// Directed bench for axim_wr_ctrl with a reactive AXI slave / stream source.
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module tb_axim_wr_ctrl;

   logic        clk = 1'b0;
   logic        rstn;
   logic [31:0] ctrl_waddr_offset;
   logic [31:0] ctrl_wxfer_size;
   logic        ctrl_wstart;
   logic        ctrl_wdone;
   logic        ctrl_werr;
   logic [31:0] wr_tdata;
   logic        wr_tvalid;
   logic        wr_tready;

   axim_wr_ctrl_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) m_axi ();

   axim_wr_ctrl #(
      .C_M_AXI_ADDR_WIDTH(32),
      .C_M_AXI_DATA_WIDTH(32),
      .C_XFER_SIZE_WIDTH (32),
      .MAX_BURST_LEN     (16)
   ) dut (
      .clk                 (clk),
      .rstn                (rstn),
      .ctrl_waddr_offset_i (ctrl_waddr_offset),
      .ctrl_wxfer_size_i   (ctrl_wxfer_size),
      .ctrl_wstart_i       (ctrl_wstart),
      .ctrl_wdone_o        (ctrl_wdone),
      .ctrl_werr_o         (ctrl_werr),
      .wr_tdata_i          (wr_tdata),
      .wr_tvalid_i         (wr_tvalid),
      .wr_tready_o         (wr_tready),
      .m_axi               (m_axi)
   );

   always #5 clk = ~clk;

   int checks   = 0;
   int failures = 0;

   // test knobs (main process only)
   bit stall_en  = 1'b0;
   int err_burst = -1;
   int clear_seq = 0;

   // slave-model observations (slave process only)
   logic [31:0] aw_addr_q[$];
   logic [7:0]  aw_len_q[$];
   logic [3:0]  w_strb_q[$];
   logic        w_last_q[$];
   int src_idx, open_bursts, pending_b, w_beat, cur_len;
   int b_cnt, prot_err, data_err, done_cnt, awv_cycles;
   logic werr_at_done;

   function automatic logic [31:0] pat(input int idx);
      return 32'hC0DE_0000 ^ (idx * 32'h0001_9E37);
   endfunction

   task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
      end
   endtask

   // Reactive AXI slave, stream source and protocol monitor
   initial begin : slave_model
      int  last_seq;
      bit  aw_fire, w_fire, b_fire, s_fire;
      last_seq = 0;
      src_idx = 0; open_bursts = 0; pending_b = 0; w_beat = 0; cur_len = 0;
      b_cnt = 0; prot_err = 0; data_err = 0; done_cnt = 0; awv_cycles = 0;
      werr_at_done = 1'b0;
      m_axi.awready = 1'b0; m_axi.wready = 1'b0;
      m_axi.bvalid = 1'b0;  m_axi.bresp = 2'b00;
      wr_tvalid = 1'b0;     wr_tdata = pat(0);
      forever begin
         @(negedge clk);
         if (clear_seq != last_seq) begin
            last_seq = clear_seq;
            aw_addr_q.delete(); aw_len_q.delete(); w_strb_q.delete(); w_last_q.delete();
            open_bursts = 0; pending_b = 0; w_beat = 0; cur_len = 0;
            b_cnt = 0; prot_err = 0; data_err = 0; done_cnt = 0; awv_cycles = 0;
            werr_at_done = 1'b0;
         end
         aw_fire = rstn && m_axi.awvalid && m_axi.awready;
         w_fire  = rstn && m_axi.wvalid && m_axi.wready;
         b_fire  = rstn && m_axi.bvalid && m_axi.bready;
         s_fire  = rstn && wr_tvalid && wr_tready;
         if (rstn && m_axi.awvalid) awv_cycles++;
         if (rstn && ctrl_wdone) begin
            done_cnt++;
            werr_at_done = ctrl_werr;
         end
         if (aw_fire) begin
            if (open_bursts != 0 || pending_b != 0) prot_err++;
            if (m_axi.awsize != 3'd2 || m_axi.awburst != 2'b01) prot_err++;
            if (int'(m_axi.awaddr[11:0]) + (int'(m_axi.awlen) + 1) * 4 > 4096) prot_err++;
            aw_addr_q.push_back(m_axi.awaddr);
            aw_len_q.push_back(m_axi.awlen);
            cur_len = int'(m_axi.awlen);
            open_bursts++;
            w_beat = 0;
         end
         if (w_fire) begin
            if (open_bursts == 0) prot_err++;
            if (m_axi.wlast !== (w_beat == cur_len)) prot_err++;
            if (m_axi.wdata !== pat(src_idx)) data_err++;
            w_strb_q.push_back(m_axi.wstrb);
            w_last_q.push_back(m_axi.wlast);
            if (m_axi.wlast) begin
               w_beat = 0;
               if (open_bursts > 0) open_bursts--;
               pending_b++;
            end else begin
               w_beat++;
            end
         end
         if (b_fire) begin
            if (pending_b == 0) prot_err++;
            else pending_b--;
            b_cnt++;
         end
         @(posedge clk);
         #1;
         if (s_fire) src_idx++;
         wr_tdata = pat(src_idx);
         if (!(wr_tvalid && !s_fire))
            wr_tvalid = stall_en ? 1'($urandom_range(0, 1)) : 1'b1;
         m_axi.awready = stall_en ? 1'($urandom_range(0, 1)) : 1'b1;
         m_axi.wready  = stall_en ? 1'($urandom_range(0, 1)) : 1'b1;
         if (!(m_axi.bvalid && !b_fire)) begin
            if (pending_b > 0 && (!stall_en || $urandom_range(0, 2) == 0)) begin
               m_axi.bvalid = 1'b1;
               m_axi.bresp  = (b_cnt == err_burst) ? 2'b10 : 2'b00;
            end else begin
               m_axi.bvalid = 1'b0;
               m_axi.bresp  = 2'b00;
            end
         end
      end
   end

   task automatic clear_model();
      clear_seq++;
      @(negedge clk);
      #1;
   endtask

   task automatic do_start(input logic [31:0] a, input logic [31:0] s);
      @(posedge clk); #1;
      ctrl_waddr_offset = a;
      ctrl_wxfer_size   = s;
      ctrl_wstart       = 1'b1;
      @(posedge clk); #1;
      ctrl_wstart       = 1'b0;
   endtask

   task automatic wait_done(input string tag, input int budget);
      int n;
      n = 0;
      while (done_cnt == 0 && n < budget) begin
         @(negedge clk); #1;
         n++;
      end
      if (done_cnt == 0) check({tag, "_timeout"}, 64'd0, 64'd1);
   endtask

   task automatic idle_cycles(input int n);
      repeat (n) @(negedge clk);
      #1;
   endtask

   task automatic check_idle_outs(input string tag);
      check(tag, {m_axi.awvalid, m_axi.wvalid, m_axi.wlast, m_axi.bready,
                  wr_tready, ctrl_wdone, ctrl_werr}, 64'd0);
   endtask

   initial begin : main
      int bad;
      int n;
      rstn = 1'b0; ctrl_wstart = 1'b0;
      ctrl_waddr_offset = '0; ctrl_wxfer_size = '0;
      repeat (3) @(posedge clk);
      @(negedge clk); #1;
      check_idle_outs("reset_outs");
      rstn = 1'b1;
      clear_model();

      // 1: 4096 bytes page-aligned, no stalls
      do_start(32'h4000_0000, 32'd4096);
      wait_done("t1", 5000);
      idle_cycles(5);
      check("t1_aw_count", aw_addr_q.size(), 64);
      bad = 0;
      for (int i = 0; i < aw_addr_q.size(); i++) begin
         if (aw_addr_q[i] !== 32'h4000_0000 + 32'(i * 64)) bad++;
         if (aw_len_q[i] !== 8'd15) bad++;
      end
      check("t1_aw_fields", bad, 0);
      check("t1_w_beats", w_strb_q.size(), 1024);
      bad = 0;
      foreach (w_strb_q[i]) if (w_strb_q[i] !== 4'hF) bad++;
      check("t1_strb", bad, 0);
      check("t1_b_count", b_cnt, 64);
      check("t1_done_once", done_cnt, 1);
      check("t1_proto", prot_err, 0);
      check("t1_data", data_err, 0);
      check("t1_werr", werr_at_done, 1'b0);

      // 2: 4KB page split
      clear_model();
      do_start(32'h0000_0FF0, 32'd64);
      wait_done("t2", 500);
      check("t2_aw_count", aw_addr_q.size(), 2);
      if (aw_addr_q.size() == 2) begin
         check("t2_addr0", aw_addr_q[0], 32'h0000_0FF0);
         check("t2_len0", aw_len_q[0], 8'd3);
         check("t2_addr1", aw_addr_q[1], 32'h0000_1000);
         check("t2_len1", aw_len_q[1], 8'd11);
      end
      check("t2_w_beats", w_strb_q.size(), 16);
      check("t2_proto", prot_err, 0);

      // 3: partial tail word, then zero-length command
      clear_model();
      do_start(32'h0000_0100, 32'd10);
      wait_done("t3", 200);
      check("t3_aw_count", aw_addr_q.size(), 1);
      if (aw_addr_q.size() == 1) begin
         check("t3_addr", aw_addr_q[0], 32'h0000_0100);
         check("t3_len", aw_len_q[0], 8'd2);
      end
      check("t3_w_beats", w_strb_q.size(), 3);
      if (w_strb_q.size() == 3) begin
         check("t3_strb0", w_strb_q[0], 4'hF);
         check("t3_last1", w_last_q[1], 1'b0);
         check("t3_strb2", w_strb_q[2], 4'b0011);
         check("t3_last2", w_last_q[2], 1'b1);
      end
      check("t3_proto", prot_err, 0);
      clear_model();
      do_start(32'h0000_0200, 32'd0);
      wait_done("t3z", 10);
      idle_cycles(3);
      check("t3z_done_once", done_cnt, 1);
      check("t3z_no_awvalid", awv_cycles, 0);

      // 4: random stalls on every channel
      clear_model();
      stall_en = 1'b1;
      do_start(32'h0000_0800, 32'd4096);
      wait_done("t4", 30000);
      idle_cycles(5);
      stall_en = 1'b0;
      check("t4_aw_count", aw_addr_q.size(), 64);
      bad = 0;
      for (int i = 0; i < aw_addr_q.size(); i++) begin
         if (aw_addr_q[i] !== 32'h0000_0800 + 32'(i * 64)) bad++;
         if (aw_len_q[i] !== 8'd15) bad++;
      end
      check("t4_aw_fields", bad, 0);
      check("t4_w_beats", w_strb_q.size(), 1024);
      check("t4_data", data_err, 0);
      check("t4_proto", prot_err, 0);
      check("t4_done_once", done_cnt, 1);

      // 5: SLVERR on second of four bursts, then cleared by next start
      clear_model();
      err_burst = 1;
      do_start(32'h0000_2000, 32'd256);
      wait_done("t5", 1000);
      check("t5_b_count", b_cnt, 4);
      check("t5_werr_at_done", werr_at_done, 1'b1);
      idle_cycles(2);
      check("t5_werr_sticky", ctrl_werr, 1'b1);
      err_burst = -1;
      clear_model();
      do_start(32'h0000_0000, 32'd8);
      @(negedge clk); #1;
      check("t5_werr_clr", ctrl_werr, 1'b0);
      wait_done("t5b", 200);
      check("t5b_werr_at_done", werr_at_done, 1'b0);

      // 6: reset mid-burst, clean restart, start while busy ignored
      clear_model();
      do_start(32'h0000_0000, 32'd4096);
      n = 0;
      while (w_strb_q.size() < 5 && n < 200) begin
         @(negedge clk); #1;
         n++;
      end
      check("t6_reached_wdata", w_strb_q.size() >= 5, 1'b1);
      rstn = 1'b0;
      repeat (2) @(posedge clk);
      @(negedge clk); #1;
      check_idle_outs("t6_reset_outs");
      clear_model();
      rstn = 1'b1;
      do_start(32'h0000_0300, 32'd32);
      n = 0;
      while (aw_addr_q.size() == 0 && n < 50) begin
         @(negedge clk); #1;
         n++;
      end
      check("t6_aw_seen", aw_addr_q.size(), 1);
      do_start(32'h0000_7000, 32'd4);
      wait_done("t6", 200);
      idle_cycles(10);
      check("t6_aw_count", aw_addr_q.size(), 1);
      if (aw_addr_q.size() == 1) begin
         check("t6_addr", aw_addr_q[0], 32'h0000_0300);
         check("t6_len", aw_len_q[0], 8'd7);
      end
      check("t6_w_beats", w_strb_q.size(), 8);
      check("t6_done_once", done_cnt, 1);
      check("t6_data", data_err, 0);
      check("t6_proto", prot_err, 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

`default_nettype wire
